// File: rtl/shift_sub_divide.sv
// Sequential signed fixed-point divider: quotient = (dividend << NFRAC) / divisor.
// Restoring shift-subtract, one quotient bit per clock, with sign/saturation applied on the final cycle.
module shift_sub_divide #(
  parameter int BITS  = 17,
  parameter int NFRAC = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [BITS-1:0] dividend,
  input  logic signed [BITS-1:0] divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [BITS-1:0] quotient,
  output logic                   div_by_zero,
  output logic                   saturated
);

  localparam int N  = BITS + NFRAC;
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] QMAX_POS = N'((1 << (BITS-1)) - 1);
  localparam logic [N-1:0] QMAX_NEG = N'(1 << (BITS-1));
  localparam logic signed [BITS-1:0] MAXV = {1'b0, {(BITS-1){1'b1}}};
  localparam logic signed [BITS-1:0] MINV = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t          state;
  logic            neg;
  logic            zero;
  logic            dvd_neg;
  logic [N-1:0]    work;
  logic [BITS-1:0] dvs;
  logic [BITS:0]   rem;
  logic [BITS:0]   trial;
  logic [CW-1:0]   cnt;
  logic            ge;
  logic [BITS+1:0] fin_res;

  // The most negative operand maps to 2^(BITS-1), which still fits unsigned BITS bits.
  function automatic logic [BITS-1:0] magnitude(input logic signed [BITS-1:0] v);
    logic [BITS-1:0] u;
    u = v;
    return u[BITS-1] ? (~u + 1'b1) : u;
  endfunction

  // Returns {quotient, div_by_zero, saturated} from the unsigned magnitude.
  function automatic logic [BITS+1:0] apply_sign_sat(
    input logic [N-1:0] q,
    input logic         neg_r,
    input logic         zero_r,
    input logic         dneg_r
  );
    logic [BITS-1:0] qs;
    if (zero_r)
      return {dneg_r ? MINV : MAXV, 2'b11};
    if (!neg_r && q > QMAX_POS)
      return {MAXV, 2'b01};
    if (neg_r && q > QMAX_NEG)
      return {MINV, 2'b01};
    qs = neg_r ? (~q[BITS-1:0] + 1'b1) : q[BITS-1:0];
    return {qs, 2'b00};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign trial     = {rem[BITS-1:0], work[N-1]};
  assign ge        = (trial >= {1'b0, dvs});
  assign fin_res   = apply_sign_sat(work, neg, zero, dvd_neg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      saturated   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          neg     <= dividend[BITS-1] ^ divisor[BITS-1];
          zero    <= (divisor == '0);
          dvd_neg <= dividend[BITS-1];
          work    <= {magnitude(dividend), {NFRAC{1'b0}}};
          dvs     <= magnitude(divisor);
          rem     <= '0;
          cnt     <= '0;
          state   <= CALC;
        end
        // work doubles as the dividend shifter and the quotient accumulator
        CALC: begin
          rem  <= ge ? (trial - {1'b0, dvs}) : trial;
          work <= {work[N-2:0], ge};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(N-1))
            state <= FIN;
        end
        FIN: begin
          quotient    <= $signed(fin_res[BITS+1:2]);
          div_by_zero <= fin_res[1];
          saturated   <= fin_res[0];
          state       <= DONE;
        end
        DONE: if (out_ready)
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divide.sv
// Randomised and directed bench for shift_sub_divide, checked every cycle against
// an arithmetic model of (dividend * 2^8) / divisor with truncation and saturation.
module tb_shift_sub_divide;

  localparam int LAT  = 26;
  localparam int QMAX = 65535;
  localparam int QMIN = -65536;

  logic               clk = 0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [16:0] dividend;
  logic signed [16:0] divisor;
  logic               out_valid;
  logic               out_ready;
  logic signed [16:0] quotient;
  logic               div_by_zero;
  logic               saturated;

  shift_sub_divide dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .div_by_zero(div_by_zero),
    .saturated(saturated)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model(input int a, input int b, output int q, output bit dz, output bit sat);
    longint num, r;
    dz = 0; sat = 0;
    num = longint'(a) * 256;
    if (b == 0) begin
      dz = 1; sat = 1;
      q = (a >= 0) ? QMAX : QMIN;
    end else begin
      r = num / b;
      if (r > QMAX) begin q = QMAX; sat = 1; end
      else if (r < QMIN) begin q = QMIN; sat = 1; end
      else q = int'(r);
    end
  endfunction

  typedef struct { int q; bit dz; bit sat; int due; } exp_t;

  // Per-cycle comparison against the model; runs mid-cycle, away from the active edge.
  exp_t cur;
  bit   have = 0;
  int   hq = 0;
  bit   hdz = 0, hsat = 0;
  always @(negedge clk) if (mon_en) begin
    bit exp_ov;
    exp_ov = have && (cyc >= cur.due);
    if (exp_ov) begin hq = cur.q; hdz = cur.dz; hsat = cur.sat; end
    chk("in_ready", int'(in_ready), int'(!have));
    chk("out_valid", int'(out_valid), int'(exp_ov));
    chk("quotient", int'(quotient), hq);
    chk("div_by_zero", int'(div_by_zero), int'(hdz));
    chk("saturated", int'(saturated), int'(hsat));
    if (reset) begin
      have = 0; hq = 0; hdz = 0; hsat = 0;
    end else if (exp_ov && out_ready) begin
      have = 0;
    end else if (!have && in_valid) begin
      model(int'(dividend), int'(divisor), cur.q, cur.dz, cur.sat);
      cur.due = cyc + 1 + LAT;
      have = 1;
    end
  end

  task automatic wait_idle();
    int w = 0;
    @(posedge clk); #1;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    chk("wait_in_ready_timeout", int'(in_ready), 1);
  endtask

  task automatic op(input int a, input int b, input int eq, input bit edz, input bit esat,
                    input bit lit, input int hold, input string nm);
    int k = 0;
    wait_idle();
    out_ready = (hold == 0);
    dividend = a[16:0];
    divisor  = b[16:0];
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    dividend = 17'($urandom);
    divisor  = 17'($urandom);
    while (!out_valid && k < 100) begin
      chk({nm, "_busy_in_ready"}, int'(in_ready), 0);
      @(posedge clk); #1; k++;
    end
    chk({nm, "_latency"}, k, LAT);
    if (lit) begin
      chk({nm, "_q"}, int'(quotient), eq);
      chk({nm, "_dz"}, int'(div_by_zero), int'(edz));
      chk({nm, "_sat"}, int'(saturated), int'(esat));
    end
    if (hold > 0) begin
      repeat (hold) begin
        in_valid = 1'($urandom);
        dividend = 17'($urandom);
        @(posedge clk); #1;
        chk({nm, "_hold_in_ready"}, int'(in_ready), 0);
        chk({nm, "_hold_valid"}, int'(out_valid), 1);
      end
      in_valid = 0;
      out_ready = 1;
      @(posedge clk); #1;
      chk({nm, "_release_in_ready"}, int'(in_ready), 1);
      chk({nm, "_release_valid"}, int'(out_valid), 0);
      if (lit) chk({nm, "_release_q_kept"}, int'(quotient), eq);
    end
  endtask

  initial begin
    int mq;
    bit mdz, msat;
    int a, b, h;
    bit seen;

    reset = 1; in_valid = 0; out_ready = 1; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_flags", int'({div_by_zero, saturated}), 0);

    model(768, 512, mq, mdz, msat);   chk("model_pin_1p5", mq, 384);
    model(-256, 768, mq, mdz, msat);  chk("model_pin_trunc", mq, -85);
    model(-65536, 256, mq, mdz, msat); chk("model_pin_minsat", int'(msat), 0);
    mon_en = 1;

    op(768, 512, 384, 0, 0, 1, 0, "div_3_by_2");
    op(-1280, 512, -640, 0, 0, 1, 0, "neg5_by_2");
    op(256, 768, 85, 0, 0, 1, 0, "trunc_pos");
    op(-256, 768, -85, 0, 0, 1, 0, "trunc_neg");
    op(65535, 1, 65535, 0, 1, 1, 0, "sat_pos");
    op(-65536, 1, -65536, 0, 1, 1, 0, "sat_neg");
    op(-65536, 256, -65536, 0, 0, 1, 0, "min_exact");
    op(256, 0, 65535, 1, 1, 1, 0, "dz_pos");
    op(-256, 0, -65536, 1, 1, 1, 0, "dz_neg");
    op(0, 0, 65535, 1, 1, 1, 0, "dz_zero");
    op(300, -7, -10971, 0, 0, 1, 5, "backpressure");
    op(1000, -7, -36571, 0, 0, 1, 0, "b2b_first");
    op(7, 1000, 1, 0, 0, 1, 0, "b2b_second");

    // Abort an operation mid-calculation with a one-cycle reset.
    wait_idle();
    dividend = 17'sd1000; divisor = 17'sd3; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk("abort_no_output", int'(seen), 0);
    op(512, 256, 512, 0, 0, 1, 0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 131071) - 65536;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 131071) - 65536;
        1: b = $urandom_range(1, 600);
        2: b = -$urandom_range(1, 600);
        default: b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 131071) - 65536;
      endcase
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      model(a, b, mq, mdz, msat);
      op(a, b, mq, mdz, msat, 1, h, "random");
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_sub_divide.md
Name: shift_sub_divide

Overview:
- Sequential signed fixed-point divider. It is the inverse counterpart of the constant-weight shift-add multiplier in the RNN datapath.
- Computes quotient = (dividend << NFRAC) / divisor by restoring shift-subtract, producing one quotient bit per clock with no DSP usage.
- Used for runtime normalisation and scaling in the GRU and RNN pipelines, where the divisor is not a compile-time constant.
- Operands and results are two's-complement Q(BITS-NFRAC).NFRAC.

Parameters:
- BITS, 17, operand and result width in bits (signed).
- NFRAC, 8, number of fractional bits in dividend, divisor and quotient.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  dividend/divisor pair is valid.
- in_ready  output  1  block can accept a new pair.
- dividend  input  BITS  signed fixed-point numerator.
- divisor  input  BITS  signed fixed-point denominator.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- quotient  output  BITS  signed fixed-point result.
- div_by_zero  output  1  divisor was zero; qualified by out_valid.
- saturated  output  1  result was clipped to the BITS range; qualified by out_valid.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- On reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, div_by_zero=0, saturated=0. Reset overrides every state, including mid-CALC and DONE; any in-flight operation is discarded with no output.
- Define N = BITS+NFRAC (25 by default).
- States: IDLE, CALC, FIN, DONE.
- in_ready = (state==IDLE), combinational from the state register. out_valid = (state==DONE).
- IDLE: a transfer occurs when in_valid and in_ready are both high at a clock edge. At that edge the block:
  - latches the result sign (dividend[BITS-1] XOR divisor[BITS-1]);
  - latches the zero-divisor flag;
  - loads |dividend| << NFRAC into an N-bit unsigned working register;
  - loads |divisor| into a BITS-bit unsigned register;
  - clears the BITS+1-bit partial remainder and the iteration counter;
  - moves to CALC.
- Magnitudes of -2^(BITS-1) are taken as unsigned 2^(BITS-1) with no overflow.
- CALC, exactly N cycles, one quotient bit per cycle, MSB first:
  - rem = {rem, next dividend bit};
  - if rem >= |divisor|, subtract |divisor| and shift in 1; otherwise shift in 0.
  - The counter is compared against N-1; on the Nth cycle move to FIN.
- FIN, one cycle. Apply sign and saturation to the N-bit unsigned magnitude q, then register quotient, div_by_zero and saturated and move to DONE:
  - Divisor zero: quotient = 2^(BITS-1)-1 if dividend >= 0, otherwise -2^(BITS-1); div_by_zero=1; saturated=1.
  - Positive result with q > 2^(BITS-1)-1: quotient = 2^(BITS-1)-1, saturated=1.
  - Negative result with q > 2^(BITS-1): quotient = -2^(BITS-1), saturated=1.
  - Otherwise quotient = sign ? -q : q, flags 0.
  - Rounding is truncation toward zero; the remainder is discarded.
- DONE: quotient and flags are held stable while out_ready=0. On an edge with out_ready=1, move to IDLE. out_valid drops the next cycle; quotient and flags keep their values. A new input cannot be accepted in the same cycle as an output transfer.
- Latency: out_valid rises N+1 edges after the input-transfer edge (26 for defaults).
- Minimum initiation interval: N+3 cycles with out_ready held high.
- in_valid is ignored outside IDLE. Input data is only sampled at the transfer edge, so operands may change freely afterwards.

Test Plan:
- 768 (3.0) / 512 (2.0) -> out_valid exactly 26 cycles after acceptance; quotient=384 (1.5); flags 0; in_ready low throughout.
- -1280 (-5.0) / 512 -> -640. Then 256 / 768 -> 85, and -256 / 768 -> -85 (truncation toward zero). Flags 0 for all three.
- Saturation: 65535 / 1 -> 65535 with saturated=1. -65536 / 1 -> -65536 with saturated=1. -65536 / 256 -> -65536 with saturated=0.
- Divide by zero: 256/0 -> 65535 with div_by_zero=1, saturated=1. -256/0 -> -65536 with both flags 1. 0/0 -> 65535 with div_by_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> quotient and flags stable, in_ready=0, and in_valid pulses are ignored. Release -> IDLE next cycle. Then back-to-back 1000/-7 -> -36571 followed by 7/1000 -> 1 (1792/1000 truncated).
- Reset asserted for 1 cycle at CALC cycle 10 -> next cycle in_ready=1, out_valid=0, no output for the aborted operation. A following 512/256 returns 512 after 26 cycles.
